// File: rtl/decode_pkg.sv
// Shared constants and types for the instruction decode stage: opcode
// class nibbles, ALU operation codes, the decoded-field payload and the
// handshake state enumeration.
package decode_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CODE_W  = 8;

  // ALU operation codes presented on instruction_out
  localparam logic [CODE_W-1:0] OP_NONE = 8'h00;
  localparam logic [CODE_W-1:0] OP_AND  = 8'h01;
  localparam logic [CODE_W-1:0] OP_OR   = 8'h02;
  localparam logic [CODE_W-1:0] OP_XOR  = 8'h03;
  localparam logic [CODE_W-1:0] OP_ADD  = 8'h05;
  localparam logic [CODE_W-1:0] OP_SUB  = 8'h09;
  localparam logic [CODE_W-1:0] OP_CMP  = 8'h0B;
  localparam logic [CODE_W-1:0] OP_MOV  = 8'h0D;
  localparam logic [CODE_W-1:0] OP_MUL  = 8'h0E;
  localparam logic [CODE_W-1:0] OP_LOAD = 8'h40;
  localparam logic [CODE_W-1:0] OP_STOR = 8'h44;
  localparam logic [CODE_W-1:0] OP_LSH  = 8'h84;
  localparam logic [CODE_W-1:0] OP_ASHU = 8'h86;
  localparam logic [CODE_W-1:0] OP_LUI  = 8'hF0;

  // Instruction class nibble, instruction[15:12]
  localparam logic [3:0] CLS_REG   = 4'h0;
  localparam logic [3:0] CLS_ANDI  = 4'h1;
  localparam logic [3:0] CLS_ORI   = 4'h2;
  localparam logic [3:0] CLS_XORI  = 4'h3;
  localparam logic [3:0] CLS_MEM   = 4'h4;
  localparam logic [3:0] CLS_ADDI  = 4'h5;
  localparam logic [3:0] CLS_SHIFT = 4'h8;
  localparam logic [3:0] CLS_SUBI  = 4'h9;
  localparam logic [3:0] CLS_CMPI  = 4'hB;
  localparam logic [3:0] CLS_MOVI  = 4'hD;
  localparam logic [3:0] CLS_MULI  = 4'hE;
  localparam logic [3:0] CLS_LUI   = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Decoded fields except the width-parameterised immediate
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [3:0]        r_dest;
    logic [3:0]        r_src;
    logic              c_in;
    logic              ri;
    logic              d_type;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/decode_if.sv
// Handshake bus of the decode stage.
// master: upstream/downstream side (drives flush, in_valid, instruction_in,
//         out_ready). slave: the decode stage (drives in_ready, out_valid and
//         all decoded fields). illegal_cnt exists only with
//         DECODE_ILLEGAL_CNT_EN defined.
interface decode_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
);

  if (DATA_W < 16) begin : g_bad_data_w
    $error("decode_if: DATA_W must be >= 16");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("decode_if: CNT_W must be >= 1");
  end

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instruction_in;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        instruction_out;
  logic [3:0]        R_dest;
  logic [3:0]        R_src;
  logic [DATA_W-1:0] immediate;
  logic              c_in;
  logic              RI_out;
  logic              d_type;
  logic              illegal;
`ifdef DECODE_ILLEGAL_CNT_EN
  logic [CNT_W-1:0]  illegal_cnt;
`endif

  modport master (
    output flush, in_valid, instruction_in, out_ready,
    input  in_ready, out_valid, instruction_out, R_dest, R_src, immediate,
           c_in, RI_out, d_type, illegal
`ifdef DECODE_ILLEGAL_CNT_EN
    , input illegal_cnt
`endif
  );

  modport slave (
    input  flush, in_valid, instruction_in, out_ready,
    output in_ready, out_valid, instruction_out, R_dest, R_src, immediate,
           c_in, RI_out, d_type, illegal
`ifdef DECODE_ILLEGAL_CNT_EN
    , output illegal_cnt
`endif
  );

endinterface

// File: rtl/decode_comb.sv
// Purely combinational field decode of one 16-bit instruction.
// Ports: instr (raw instruction), fields_c (operation code, registers,
// flags), immediate_c (extended immediate, DATA_W bits).
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_t               fields_c,
  output logic [DATA_W-1:0]  immediate_c
);

  logic [3:0]        cls;
  logic [3:0]        sub;
  logic [7:0]        op;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] sext8;
  logic [DATA_W-1:0] zext8;
  logic              bad;

  assign cls   = instr[15:12];
  assign sub   = instr[7:4];
  assign op    = {cls, sub};
  assign imm8  = instr[7:0];
  assign sext8 = {{(DATA_W-8){imm8[7]}}, imm8};
  assign zext8 = DATA_W'(imm8);

  // Class first, then the sub-opcode inside the classes that share a nibble
  always_comb begin
    fields_c        = '0;
    fields_c.r_dest = instr[11:8];
    fields_c.r_src  = instr[3:0];
    fields_c.d_type = (cls == CLS_MEM);
    immediate_c     = '0;
    bad             = 1'b0;
    case (cls)
      CLS_REG: begin
        if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_CMP, OP_AND, OP_XOR, OP_MOV})
          fields_c.code = op;
        else
          bad = 1'b1;
      end
      CLS_MEM: begin
        if (op == OP_LOAD || op == OP_STOR) fields_c.code = op;
        else                                bad = 1'b1;
      end
      CLS_SHIFT: begin
        if (op == OP_LSH || op == OP_ASHU) begin
          fields_c.code = op;
        end else if (sub[3:1] == 3'b000) begin
          // LSHI: 5-bit signed shift amount
          fields_c.code = OP_LSH;
          fields_c.ri   = 1'b1;
          immediate_c   = {{(DATA_W-5){instr[4]}}, instr[4:0]};
        end else begin
          bad = 1'b1;
        end
      end
      CLS_ADDI: begin fields_c.code = OP_ADD; fields_c.ri = 1'b1; immediate_c = sext8; end
      CLS_MULI: begin fields_c.code = OP_MUL; fields_c.ri = 1'b1; immediate_c = sext8; end
      CLS_CMPI: begin fields_c.code = OP_CMP; fields_c.ri = 1'b1; immediate_c = sext8; end
      CLS_SUBI: begin
        // a - b computed as a + ~b + 1
        fields_c.code = OP_ADD;
        fields_c.ri   = 1'b1;
        fields_c.c_in = 1'b1;
        immediate_c   = ~sext8;
      end
      CLS_ANDI: begin fields_c.code = OP_AND; fields_c.ri = 1'b1; immediate_c = zext8; end
      CLS_ORI:  begin fields_c.code = OP_OR;  fields_c.ri = 1'b1; immediate_c = zext8; end
      CLS_XORI: begin fields_c.code = OP_XOR; fields_c.ri = 1'b1; immediate_c = zext8; end
      CLS_MOVI: begin fields_c.code = OP_MOV; fields_c.ri = 1'b1; immediate_c = zext8; end
      CLS_LUI: begin
        fields_c.code = OP_LUI;
        fields_c.ri   = 1'b1;
        immediate_c   = DATA_W'({imm8, 8'h00});
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      fields_c.code    = OP_NONE;
      fields_c.ri      = 1'b1;
      fields_c.c_in    = 1'b0;
      fields_c.illegal = 1'b1;
      immediate_c      = '0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on the input path, holds results in an
// output register plus a one-entry skid register with valid/ready handshake.
// Ports: clk, reset (async, active-high), bus (decode_if.slave).
// Optional DECODE_ILLEGAL_CNT_EN adds a saturating count of delivered
// illegal instructions on bus.illegal_cnt.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input logic     clk,
  input logic     reset,
  decode_if.slave bus
);

  if (DATA_W < 16) begin : g_bad_data_w
    $error("decode_stage: DATA_W must be >= 16");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("decode_stage: CNT_W must be >= 1");
  end

  dec_t              in_fields_c;
  logic [DATA_W-1:0] in_imm_c;

  decode_comb #(.DATA_W(DATA_W)) u_decode (
    .instr       (bus.instruction_in),
    .fields_c    (in_fields_c),
    .immediate_c (in_imm_c)
  );

  state_t            state_q, state_d;
  logic              in_ready_q, out_valid_q;
  dec_t              out_q, skid_q;
  logic [DATA_W-1:0] out_imm_q, skid_imm_q;
  logic              accept_c, deliver_c;
  logic              load_out_in_c, load_out_skid_c, load_skid_c;

  assign accept_c  = bus.in_valid & in_ready_q;
  assign deliver_c = out_valid_q & bus.out_ready;

  // State register; in_ready/out_valid are registered images of the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Next state and register load selects
  always_comb begin
    state_d         = state_q;
    load_out_in_c   = 1'b0;
    load_out_skid_c = 1'b0;
    load_skid_c     = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d       = ST_ONE;
            load_out_in_c = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_c && deliver_c) begin
            load_out_in_c = 1'b1;
          end else if (accept_c) begin
            state_d     = ST_FULL;
            load_skid_c = 1'b1;
          end else if (deliver_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deliver_c) begin
            state_d         = ST_ONE;
            load_out_skid_c = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output and skid data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      out_imm_q  <= '0;
      skid_q     <= '0;
      skid_imm_q <= '0;
    end else begin
      if (load_out_in_c) begin
        out_q     <= in_fields_c;
        out_imm_q <= in_imm_c;
      end else if (load_out_skid_c) begin
        out_q     <= skid_q;
        out_imm_q <= skid_imm_q;
      end
      if (load_skid_c) begin
        skid_q     <= in_fields_c;
        skid_imm_q <= in_imm_c;
      end
    end
  end

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of illegal instructions handed downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (deliver_c && !bus.flush && out_q.illegal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.illegal_cnt = cnt_q;
`endif

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.instruction_out = out_q.code;
  assign bus.R_dest          = out_q.r_dest;
  assign bus.R_src           = out_q.r_src;
  assign bus.immediate       = out_imm_q;
  assign bus.c_in            = out_q.c_in;
  assign bus.RI_out          = out_q.ri;
  assign bus.d_type          = out_q.d_type;
  assign bus.illegal         = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 16-bit and a 32-bit instance share one stimulus
// stream; a queue model of the held instructions plus a table-based decoder
// predicts every output, checked on each falling edge, alongside literal
// expectations for the documented examples.
module tb_decode_stage;

  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [7:0]  code;
    logic [31:0] imm;
    logic        cin;
    logic        ri;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] instr;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq[$];      // instructions held by the stage, oldest first
  logic [7:0]  del_q[$];   // instruction_out of every delivered instruction
  int          exp_cnt = 0;
  exp_t        e16, e32;

  decode_if #(.DATA_W(16), .CNT_W(CNT_W)) b16 ();
  decode_if #(.DATA_W(32), .CNT_W(CNT_W)) b32 ();

  assign b16.flush = flush;          assign b32.flush = flush;
  assign b16.in_valid = in_valid;    assign b32.in_valid = in_valid;
  assign b16.instruction_in = instr; assign b32.instruction_in = instr;
  assign b16.out_ready = out_ready;  assign b32.out_ready = out_ready;

  decode_stage #(.DATA_W(16), .CNT_W(CNT_W)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  decode_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut32 (.clk(clk), .reset(reset), .bus(b32));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder written from the instruction table
  function automatic exp_t ref_decode(input logic [15:0] i, input int w);
    exp_t        e;
    logic [7:0]  op;
    logic [31:0] s8, z8;
    op    = {i[15:12], i[7:4]};
    s8    = {{24{i[7]}}, i[7:0]};
    z8    = {24'h0, i[7:0]};
    e.code = 8'h00; e.imm = 32'h0; e.cin = 1'b0; e.ri = 1'b1; e.ill = 1'b1;
    if (op inside {8'h05, 8'h09, 8'h0E, 8'h02, 8'h0B, 8'h01, 8'h03, 8'h0D,
                   8'h84, 8'h86, 8'h40, 8'h44}) begin
      e.code = op; e.ri = 1'b0; e.ill = 1'b0;
    end else if (i[15:12] == 4'h8 && i[7:5] == 3'b000) begin
      e.code = 8'h84; e.imm = {{27{i[4]}}, i[4:0]}; e.ill = 1'b0;
    end else begin
      e.ill = 1'b0;
      case (i[15:12])
        4'h5: begin e.code = 8'h05; e.imm = s8; end
        4'hE: begin e.code = 8'h0E; e.imm = s8; end
        4'hB: begin e.code = 8'h0B; e.imm = s8; end
        4'h9: begin e.code = 8'h05; e.imm = ~s8; e.cin = 1'b1; end
        4'h1: begin e.code = 8'h01; e.imm = z8; end
        4'h2: begin e.code = 8'h02; e.imm = z8; end
        4'h3: begin e.code = 8'h03; e.imm = z8; end
        4'hD: begin e.code = 8'h0D; e.imm = z8; end
        4'hF: begin e.code = 8'hF0; e.imm = {16'h0, i[7:0], 8'h00}; end
        default: e.ill = 1'b1;
      endcase
    end
    if (w < 32) e.imm = e.imm & ((32'h1 << w) - 32'h1);
    return e;
  endfunction

  // Queue model of the two-entry stage
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_cnt <= 0;
    end else if (flush) begin
      mq.delete();
    end else if (mq.size() == 2) begin
      if (out_ready) begin
        if (ref_decode(mq[0], 16).ill && exp_cnt < CNT_MAX) exp_cnt <= exp_cnt + 1;
        void'(mq.pop_front());
      end
    end else begin
      if (out_ready && mq.size() > 0) begin
        if (ref_decode(mq[0], 16).ill && exp_cnt < CNT_MAX) exp_cnt <= exp_cnt + 1;
        void'(mq.pop_front());
      end
      if (in_valid) mq.push_back(instr);
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    check("in_ready",    32'(b16.in_ready),  32'(mq.size() < 2));
    check("out_valid",   32'(b16.out_valid), 32'(mq.size() > 0));
    check("in_ready32",  32'(b32.in_ready),  32'(mq.size() < 2));
    check("out_valid32", 32'(b32.out_valid), 32'(mq.size() > 0));
    if (reset) begin
      check("rst_code",  32'(b16.instruction_out), 32'h0);
      check("rst_imm",   32'(b16.immediate), 32'h0);
      check("rst_imm32", b32.immediate, 32'h0);
      check("rst_ill",   32'(b16.illegal), 32'h0);
    end else if (mq.size() > 0) begin
      e16 = ref_decode(mq[0], 16);
      e32 = ref_decode(mq[0], 32);
      check("code",   32'(b16.instruction_out), 32'(e16.code));
      check("code32", 32'(b32.instruction_out), 32'(e32.code));
      check("imm",    32'(b16.immediate), e16.imm);
      check("imm32",  b32.immediate, e32.imm);
      check("c_in",   32'(b16.c_in), 32'(e16.cin));
      check("RI_out", 32'(b16.RI_out), 32'(e16.ri));
      check("illegal", 32'(b16.illegal), 32'(e16.ill));
      check("R_dest", 32'(b16.R_dest), 32'(mq[0][11:8]));
      check("R_src",  32'(b16.R_src), 32'(mq[0][3:0]));
      check("d_type", 32'(b16.d_type), 32'(mq[0][15:12] == 4'h4));
    end
`ifdef DECODE_ILLEGAL_CNT_EN
    check("illegal_cnt", 32'(b16.illegal_cnt), 32'(exp_cnt));
`endif
    if (!reset && !flush && b16.out_valid && out_ready) del_q.push_back(b16.instruction_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction until accepted (bounded)
  task automatic push(input logic [15:0] v);
    logic acc;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    instr    = v;
    do begin
      acc = b16.in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (!acc) check("push_timeout", 32'(n), 32'(0));
  endtask

  logic [15:0] vec[] = '{
    16'h0150, 16'h0290, 16'h03E0, 16'h0420, 16'h05B0, 16'h0610, 16'h0730, 16'h08D0,
    16'h8143, 16'h8265, 16'h831F, 16'h8305, 16'hE380, 16'hB47F, 16'h14FF, 16'h2580,
    16'h3601, 16'hD7AA, 16'h4A03, 16'h4B45, 16'h00F0, 16'h6123, 16'h4010, 16'h8350,
    16'h8A71, 16'h0C00, 16'hA000, 16'hC000, 16'h7000, 16'h9180, 16'hF2FF, 16'h5C7F
  };
  logic [4:0] rdy_pat = 5'b10110;

  initial begin
    int idx;
    logic acc;
    int n0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 16'h0;
    tick(); tick();
    check("lit_rst_in_ready",  32'(b16.in_ready), 32'h1);
    check("lit_rst_out_valid", 32'(b16.out_valid), 32'h0);
    reset = 1'b0;
    tick();

    // Documented examples
    out_ready = 1'b1;
    push(16'h53FE);
    check("lit_addi_code", 32'(b16.instruction_out), 32'h05);
    check("lit_addi_rd",   32'(b16.R_dest), 32'h3);
    check("lit_addi_imm",  32'(b16.immediate), 32'hFFFE);
    check("lit_addi_ri",   32'(b16.RI_out), 32'h1);
    check("lit_addi_cin",  32'(b16.c_in), 32'h0);
    check("lit_addi_imm32", b32.immediate, 32'hFFFF_FFFE);
    push(16'h9105);
    check("lit_subi_code", 32'(b16.instruction_out), 32'h05);
    check("lit_subi_imm",  32'(b16.immediate), 32'hFFFA);
    check("lit_subi_cin",  32'(b16.c_in), 32'h1);
    push(16'hF212);
    check("lit_lui_code",  32'(b16.instruction_out), 32'hF0);
    check("lit_lui_imm",   32'(b16.immediate), 32'h1200);
    tick();

    // Table sweep with irregular downstream backpressure
    idx = 0;
    for (int cyc = 0; cyc < 300 && idx < vec.size(); cyc++) begin
      in_valid  = 1'b1;
      instr     = vec[idx];
      out_ready = rdy_pat[cyc % 5];
      acc       = b16.in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("sweep_done", 32'(idx), 32'(vec.size()));
    out_ready = 1'b1;
    repeat (3) tick();

    // Three back-to-back with a stalled consumer
    del_q.delete();
    out_ready = 1'b0;
    push(16'h0150);
    push(16'h0290);
    check("lit_full_in_ready", 32'(b16.in_ready), 32'h0);
    in_valid = 1'b1; instr = 16'h03E0;
    tick();
    out_ready = 1'b1;
    push(16'h03E0);
    repeat (3) tick();
    check("order_count", 32'(del_q.size()), 32'd3);
    if (del_q.size() == 3) begin
      check("order_0", 32'(del_q[0]), 32'h05);
      check("order_1", 32'(del_q[1]), 32'h09);
      check("order_2", 32'(del_q[2]), 32'h0E);
    end

    // Flush while full, with a simultaneous offer
    out_ready = 1'b0;
    push(16'h0150);
    push(16'h0290);
    n0 = del_q.size();
    flush = 1'b1; in_valid = 1'b1; instr = 16'h0730;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("lit_flush_out_valid", 32'(b16.out_valid), 32'h0);
    check("lit_flush_in_ready",  32'(b16.in_ready), 32'h1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("lit_flush_nothing", 32'(del_q.size()), 32'(n0));

    // Illegal instructions and the optional counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    push(16'h00F0);
    check("lit_ill_code", 32'(b16.instruction_out), 32'h00);
    check("lit_ill_flag", 32'(b16.illegal), 32'h1);
    check("lit_ill_ri",   32'(b16.RI_out), 32'h1);
    push(16'h00F0);
    tick();
`ifdef DECODE_ILLEGAL_CNT_EN
    check("lit_ill_cnt2", 32'(b16.illegal_cnt), 32'h2);
    for (int k = 0; k < 300; k++) push(16'h00F0);
    tick();
    check("lit_ill_cnt_sat", 32'(b16.illegal_cnt), 32'hFF);
`endif

    // Asynchronous reset while full
    out_ready = 1'b0;
    push(16'h0150);
    push(16'h0290);
    #2;
    reset = 1'b1;
    #1;
    check("lit_arst_out_valid",   32'(b16.out_valid), 32'h0);
    check("lit_arst_in_ready",    32'(b16.in_ready), 32'h1);
    check("lit_arst_code",        32'(b16.instruction_out), 32'h0);
    check("lit_arst_out_valid32", 32'(b32.out_valid), 32'h0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    push(16'h53FE);
    check("lit_w32_imm", b32.immediate, 32'hFFFF_FFFE);
    check("lit_w16_imm", 32'(b16.immediate), 32'hFFFE);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath width of the immediate output; legal values >=16.
REQ-002 Parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all held instructions.
REQ-006 in_valid  input  1  instruction_in is valid.
REQ-007 in_ready  output  1  stage accepts an instruction this cycle; driven directly from a register.
REQ-008 instruction_in  input  16  raw instruction.
REQ-009 out_valid  output  1  decoded fields are valid.
REQ-010 out_ready  input  1  downstream accepts the decoded fields.
REQ-011 instruction_out  output  8  ALU operation code.
REQ-012 R_dest  output  4  instruction_in[11:8].
REQ-013 R_src  output  4  instruction_in[3:0].
REQ-014 immediate  output  DATA_W  extended immediate; 0 for register forms.
REQ-015 c_in  output  1  ALU carry-in.
REQ-016 RI_out  output  1  0 = register operand, 1 = immediate operand.
REQ-017 d_type  output  1  instruction_in[15:12]==4'b0100, i.e. load/store class.
REQ-018 illegal  output  1  current output instruction is unrecognised.
REQ-019 illegal_cnt  output  CNT_W  count of illegal instructions delivered; present only with the macro in REQ-038.

Function
REQ-020 op = {instruction_in[15:12], instruction_in[7:4]}; imm8 = instruction_in[7:0].
REQ-021 Register forms ADD 05, SUB 09, MUL 0E, OR 02, CMP 0B, AND 01, XOR 03, MOV 0D, LSH 84, ASHU 86: instruction_out = op, immediate 0, RI_out 0, c_in 0.
REQ-022 ADDI 5x, MULI Ex, CMPI Bx: instruction_out 05/0E/0B, immediate = imm8 sign-extended to DATA_W, RI_out 1.
REQ-023 SUBI 9x: instruction_out 05, immediate = bitwise NOT of the full sign-extended imm8, c_in 1, RI_out 1.
REQ-024 ANDI 1x, ORI 2x, XORI 3x, MOVI Dx: instruction_out 01/02/03/0D, immediate = imm8 zero-extended, RI_out 1.
REQ-025 LSHI: [15:12]=1000 and [7:5]=000; instruction_out 84, immediate = instruction_in[4:0] sign-extended, RI_out 1.
REQ-026 LUI Fx: instruction_out F0, immediate = {imm8, 8'h00} zero-extended, RI_out 1.
REQ-027 LOAD 40, STOR 44: instruction_out = op, RI_out 0, immediate 0.
REQ-028 Any other op: instruction_out 00, immediate 0, c_in 0, RI_out 1, illegal 1.
REQ-029 Latency: an instruction accepted at edge N appears on outputs after edge N with out_valid 1.
REQ-030 Storage: output register plus one-entry skid register; in_ready = skid empty, registered.
REQ-031 Transfer occurs when valid and ready are both 1 on the same edge; out_valid holds and outputs are stable until transfer.
REQ-032 States EMPTY (out_valid 0), ONE (output register full), FULL (both full, in_ready 0); simultaneous accept and deliver in ONE stays ONE.
REQ-033 FULL with out_ready 1: skid moves to the output register in order, next state ONE; no reordering or loss.
REQ-034 flush 1: next state EMPTY and in_ready 1; an instruction offered in the same cycle is dropped; flush overrides reset-free transfers.

Reset
REQ-035 On reset assertion, immediately: state EMPTY, out_valid 0, in_ready 1, all decoded outputs 0, illegal 0, illegal_cnt 0.
REQ-036 Reset mid-transfer discards all held instructions; the first accept after deassertion occurs no earlier than the first rising edge with reset low.

Configuration
REQ-037 Without DECODE_ILLEGAL_CNT_EN, illegal_cnt and its counter are absent; illegal flag is still produced.
REQ-038 With DECODE_ILLEGAL_CNT_EN, illegal_cnt increments by 1 on each delivered illegal instruction, saturating at all-ones; flushed instructions do not count.

Structure
REQ-039 Package decode_pkg holds all opcode constants, the instruction_out codes, and the state enumeration.
REQ-040 Combinational field decode is sub-module decode_comb, instantiated once on the input path; decode_stage holds only storage, handshake and counter.

Verification
REQ-041 0x53FE, out_ready 1 -> one cycle later instruction_out 05, R_dest 3, immediate 0xFFFE, RI_out 1, c_in 0.
REQ-042 0x9105 -> instruction_out 05, immediate 0xFFFA, c_in 1; 0xF212 -> instruction_out F0, immediate 0x1200.
REQ-043 Three back-to-back instructions with out_ready 0 for 3 cycles -> in_ready 0 after the second accept; all three delivered in order after out_ready rises.
REQ-044 0x00F0 twice, with the macro -> instruction_out 00, illegal 1, illegal_cnt 2; counter held at 0xFF after 300 illegals.
REQ-045 FULL state then flush 1 together with in_valid 1 -> next cycle out_valid 0, in_ready 1, nothing delivered.
REQ-046 Reset asserted while FULL -> out_valid 0 and in_ready 1 without waiting for a clock edge; DATA_W=32 run of REQ-041 -> immediate 0xFFFFFFFE.
